// File: rtl/gals_handshake_rx.sv
// Consumer side of the GALS link: 4-phase req/ack receiver with a req synchronizer,
// even-parity screening and a small first-word fall-through FIFO toward the consumer.
`timescale 1ns/1ps
module gals_handshake_rx #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   parity_in,
    output logic                   ack_out,
    output logic [DATA_W-1:0]      dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   parity_err,
    output logic [7:0]             err_count,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
        return ((^d) == p);
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    state_t                 state_r;
    state_t                 state_s;
    logic                   ack_r;
    logic                   ack_s;
    logic                   push_s;
    logic                   perr_s;
    logic                   pop_s;
    logic                   full_s;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       rd_nxt_s;
    logic [LVL_W-1:0]       level_r;
    logic [LVL_W-1:0]       level_s;
    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic [DATA_W-1:0]      head_r;
    logic [DATA_W-1:0]      head_s;
    logic                   valid_r;
    logic                   valid_s;
    logic                   perr_r;
    logic [7:0]             errcnt_r;

    assign req_s    = sync_r[SYNC_STAGES-1];
    assign full_s   = (level_r == FULL_LVL);
    assign pop_s    = valid_r & dout_ready;
    assign rd_nxt_s = rd_ptr_r + PTR_W'(1);

    assign ack_out    = ack_r;
    assign dout       = head_r;
    assign dout_valid = valid_r;
    assign parity_err = perr_r;
    assign err_count  = errcnt_r;
    assign level      = level_r;

    // req synchronizer; data/parity stay unsynchronized and are only sampled in CAPTURE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_in};
        end
    end

    // handshake state and registered acknowledge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ack_r   <= ack_s;
        end
    end

    // next-state decode; a full FIFO holds CAPTURE without ack, good or bad word alike
    always_comb begin
        state_s = state_r;
        ack_s   = ack_r;
        push_s  = 1'b0;
        perr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                ack_s = 1'b0;
                if (req_s) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (full_s) begin
                    ack_s   = 1'b0;
                    state_s = CAPTURE;
                end else begin
                    if (parity_ok(data_in, parity_in)) begin
                        push_s = 1'b1;
                    end else begin
                        perr_s = 1'b1;
                    end
                    ack_s   = 1'b1;
                    state_s = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    ack_s   = 1'b0;
                    state_s = IDLE;
                end else begin
                    ack_s   = 1'b1;
                    state_s = WAIT_LOW;
                end
            end
            default: begin
                ack_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // FIFO occupancy and head-register update (head survives the FIFO going empty)
    always_comb begin
        level_s = level_r;
        head_s  = head_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_W'(1);
            2'b01:   level_s = level_r - LVL_W'(1);
            default: level_s = level_r;
        endcase
        if (pop_s) begin
            if (level_r > LVL_W'(1)) begin
                head_s = mem_r[rd_nxt_s];
            end else if (push_s) begin
                head_s = data_in;
            end else begin
                head_s = head_r;
            end
        end else if (push_s && (level_r == '0)) begin
            head_s = data_in;
        end else begin
            head_s = head_r;
        end
        valid_s = (level_s != '0);
    end

    // FIFO storage, pointers and consumer-facing registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data_in;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            level_r <= level_s;
            head_r  <= head_s;
            valid_r <= valid_s;
        end
    end

    // rejected-word pulse and saturating error counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perr_r   <= 1'b0;
            errcnt_r <= 8'd0;
        end else begin
            perr_r <= perr_s;
            if (perr_s && (errcnt_r != 8'hFF)) begin
                errcnt_r <= errcnt_r + 8'd1;
            end
        end
    end

endmodule
